// File: rtl/pll_ctrl_pkg.sv
// PLL lock controller shared definitions.
// State encoding, parameter defaults and sizing helpers.
package pll_ctrl_pkg;

  localparam int RST_CYCLES_DEF    = 24;
  localparam int LOCK_WAIT_DEF     = 24000;
  localparam int STABLE_CYCLES_DEF = 240;
  localparam int MAX_RETRY_DEF     = 7;

  localparam int RELOCK_W = 8;

  localparam logic [2:0] ENC_RESET_PLL = 3'd0;
  localparam logic [2:0] ENC_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ENC_STABLE    = 3'd2;
  localparam logic [2:0] ENC_RUN       = 3'd3;
  localparam logic [2:0] ENC_FAULT     = 3'd4;

  typedef enum logic [2:0] {
    RESET_PLL = ENC_RESET_PLL,
    WAIT_LOCK = ENC_WAIT_LOCK,
    STABLE    = ENC_STABLE,
    RUN       = ENC_RUN,
    FAULT     = ENC_FAULT
  } state_e;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold values 0 .. n-1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pll_lock_ctrl_if.sv
// PLL lock controller signal bundle.
// slave = the controller, master = the surrounding system.
interface pll_lock_ctrl_if;
  import pll_ctrl_pkg::*;

  logic                extlock;
  logic                sw_relock;
  logic                pll_reset;
  logic                sys_rst;
  logic                locked;
  logic                fault;
  logic [RELOCK_W-1:0] relock_cnt;

  modport master (
    output extlock,
    output sw_relock,
    input  pll_reset,
    input  sys_rst,
    input  locked,
    input  fault,
    input  relock_cnt
  );

  modport slave (
    input  extlock,
    input  sw_relock,
    output pll_reset,
    output sys_rst,
    output locked,
    output fault,
    output relock_cnt
  );

endinterface

// File: rtl/pll_lock_ctrl_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock sequencer with retry, fault and relock tracking.
// Drives PLL reset and the system reset of PLL-clocked logic.
module pll_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = RST_CYCLES_DEF,
  parameter int LOCK_WAIT     = LOCK_WAIT_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int MAX_RETRY     = MAX_RETRY_DEF
) (
  input  logic           refclk,
  input  logic           reset,
  pll_lock_ctrl_if.slave bus
);

  localparam int TW = cnt_w(max3(RST_CYCLES, LOCK_WAIT, STABLE_CYCLES));
  localparam int RW = cnt_w(MAX_RETRY + 1);

  localparam logic [TW-1:0] T_RST    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCK   = TW'(LOCK_WAIT - 1);
  localparam logic [TW-1:0] T_STABLE = TW'(STABLE_CYCLES - 1);

  state_e              r_state;
  logic [TW-1:0]       r_timer;
  logic [RW-1:0]       r_retry;
  logic [RELOCK_W-1:0] r_relock_cnt;
  logic                r_pll_reset;
  logic                r_sys_rst;
  logic                r_locked;
  logic                r_fault;
  logic                w_lock_s;
  logic                w_retry_last;

  sync_2ff u_sync (
    .i_clk (refclk),
    .i_rst (reset),
    .i_d   (bus.extlock),
    .o_q   (w_lock_s)
  );

  assign w_retry_last = (int'(r_retry) + 1) >= MAX_RETRY;

  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      r_state      <= RESET_PLL;
      r_timer      <= '0;
      r_retry      <= '0;
      r_relock_cnt <= '0;
      r_pll_reset  <= 1'b1;
      r_sys_rst    <= 1'b1;
      r_locked     <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      // Outputs decode the state one edge late; timing is built around it.
      r_pll_reset <= (r_state == RESET_PLL) || (r_state == FAULT);
      r_sys_rst   <= (r_state != RUN);
      r_locked    <= (r_state == RUN);
      r_fault     <= (r_state == FAULT);
      unique case (r_state)
        RESET_PLL: begin
          if (r_timer == T_RST) begin
            r_state <= WAIT_LOCK;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (w_lock_s) begin
            r_state <= STABLE;
            r_timer <= '0;
          end else if (r_timer == T_LOCK) begin
            r_retry <= r_retry + 1'b1;
            r_timer <= '0;
            r_state <= w_retry_last ? FAULT : RESET_PLL;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        STABLE: begin
          if (!w_lock_s) begin
            r_state <= WAIT_LOCK;
            r_timer <= '0;
          end else if (r_timer == T_STABLE) begin
            r_state <= RUN;
            r_timer <= '0;
            r_retry <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        RUN: begin
          if (!w_lock_s || bus.sw_relock) begin
            r_state <= RESET_PLL;
            r_timer <= '0;
            if (!w_lock_s && (r_relock_cnt != '1)) begin
              r_relock_cnt <= r_relock_cnt + 1'b1;
            end
          end
        end
        FAULT: begin
          if (bus.sw_relock) begin
            r_state <= RESET_PLL;
            r_timer <= '0;
            r_retry <= '0;
          end
        end
        default: begin
          r_state <= RESET_PLL;
          r_timer <= '0;
        end
      endcase
    end
  end

  assign bus.pll_reset  = r_pll_reset;
  assign bus.sys_rst    = r_sys_rst;
  assign bus.locked     = r_locked;
  assign bus.fault      = r_fault;
  assign bus.relock_cnt = r_relock_cnt;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Scoreboard bench for pll_lock_ctrl with short timing parameters.
// Output vector is {pll_reset, sys_rst, locked, fault, relock_cnt}.
module tb_pll_lock_ctrl;

  localparam int RST_C  = 4;
  localparam int LOCK_W = 20;
  localparam int STAB_C = 8;
  localparam int MAX_R  = 3;

  typedef struct {
    int          cyc;
    string       tag;
    logic [11:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = -1;
  int   n_run = 0;
  int   n_fail = 0;
  exp_t q[$];

  pll_lock_ctrl_if bus ();

  pll_lock_ctrl #(
    .RST_CYCLES    (RST_C),
    .LOCK_WAIT     (LOCK_W),
    .STABLE_CYCLES (STAB_C),
    .MAX_RETRY     (MAX_R)
  ) dut (
    .refclk (clk),
    .reset  (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // cyc = n during the period after edge n; edge 0 is the first after release.
  always @(posedge clk) begin
    if (rst) cyc <= -1;
    else     cyc <= cyc + 1;
  end

  function automatic logic [11:0] obs();
    return {bus.pll_reset, bus.sys_rst, bus.locked,
            bus.fault, bus.relock_cnt};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic expect_at(
    input int         c,
    input string      tag,
    input logic [3:0] f,
    input logic [7:0] n
  );
    exp_t e;
    e.cyc = c;
    e.tag = tag;
    e.v   = {f, n};
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      while (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk(e.tag, 32'(obs()), 32'(e.v));
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start_scn();
    rst = 1'b1;
    bus.extlock = 1'b0;
    bus.sw_relock = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outs", 32'(obs()), 32'({4'b1100, 8'd0}));
    rst = 1'b0;
  endtask

  task automatic end_scn(input string tag);
    for (int i = 0; i < 300 && q.size() > 0; i++) @(negedge clk);
    chk({tag, ".drain"}, q.size(), 0);
    q.delete();
  endtask

  initial begin
    bus.extlock = 1'b0;
    bus.sw_relock = 1'b0;

    // Clean lock: extlock first sampled at edge 10.
    expect_at(3,  "s1.pll_hi",  4'b1100, 8'd0);
    expect_at(4,  "s1.pll_lo",  4'b0100, 8'd0);
    expect_at(20, "s1.pre_run", 4'b0100, 8'd0);
    expect_at(21, "s1.run",     4'b0010, 8'd0);
    expect_at(30, "s1.hold",    4'b0010, 8'd0);
    start_scn();
    wait_cyc(9);
    bus.extlock = 1'b1;
    end_scn("s1");

    // No lock ever: three pulses, then fault.
    expect_at(3,  "s2.p1_hi",  4'b1100, 8'd0);
    expect_at(4,  "s2.p1_lo",  4'b0100, 8'd0);
    expect_at(23, "s2.w1_end", 4'b0100, 8'd0);
    expect_at(24, "s2.p2_hi",  4'b1100, 8'd0);
    expect_at(27, "s2.p2_end", 4'b1100, 8'd0);
    expect_at(28, "s2.p2_lo",  4'b0100, 8'd0);
    expect_at(48, "s2.p3_hi",  4'b1100, 8'd0);
    expect_at(51, "s2.p3_end", 4'b1100, 8'd0);
    expect_at(52, "s2.p3_lo",  4'b0100, 8'd0);
    expect_at(71, "s2.prefault", 4'b0100, 8'd0);
    expect_at(72, "s2.fault",  4'b1101, 8'd0);
    expect_at(90, "s2.fault_hold", 4'b1101, 8'd0);
    start_scn();
    end_scn("s2");

    // Lock drops during STABLE: back to WAIT_LOCK with a fresh timer.
    expect_at(16, "s3.stable", 4'b0100, 8'd0);
    expect_at(30, "s3.wait",   4'b0100, 8'd0);
    expect_at(37, "s3.to_end", 4'b0100, 8'd0);
    expect_at(38, "s3.retry",  4'b1100, 8'd0);
    expect_at(41, "s3.pulse",  4'b1100, 8'd0);
    expect_at(42, "s3.pulse_end", 4'b0100, 8'd0);
    start_scn();
    wait_cyc(9);
    bus.extlock = 1'b1;
    wait_cyc(14);
    bus.extlock = 1'b0;
    end_scn("s3");

    // Lock loss in RUN with a coincident sw_relock, relock, loss, async reset.
    expect_at(21, "s4.run",     4'b0010, 8'd0);
    expect_at(31, "s4.loss_sync", 4'b0010, 8'd0);
    expect_at(32, "s4.cnt1",    4'b0010, 8'd1);
    expect_at(33, "s4.sysrst",  4'b1100, 8'd1);
    expect_at(36, "s4.pulse",   4'b1100, 8'd1);
    expect_at(37, "s4.pulse_end", 4'b0100, 8'd1);
    expect_at(50, "s4.pre_run", 4'b0100, 8'd1);
    expect_at(51, "s4.relock",  4'b0010, 8'd1);
    expect_at(62, "s4.cnt2",    4'b0010, 8'd2);
    expect_at(63, "s4.pulse2",  4'b1100, 8'd2);
    expect_at(66, "s4.pulse2_end", 4'b1100, 8'd2);
    expect_at(67, "s4.wait2",   4'b0100, 8'd2);
    expect_at(70, "s4.wait2b",  4'b0100, 8'd2);
    start_scn();
    wait_cyc(9);
    bus.extlock = 1'b1;
    wait_cyc(29);
    bus.extlock = 1'b0;
    wait_cyc(31);
    bus.sw_relock = 1'b1;
    wait_cyc(32);
    bus.sw_relock = 1'b0;
    wait_cyc(39);
    bus.extlock = 1'b1;
    wait_cyc(59);
    bus.extlock = 1'b0;
    wait_cyc(70);
    #2;
    rst = 1'b1;
    #1;
    chk("s4.async_rst", 32'(obs()), 32'({4'b1100, 8'd0}));
    end_scn("s4");

    // Fault exit via sw_relock, then sw_relock in RUN and STABLE.
    expect_at(72,  "s5.fault",     4'b1101, 8'd0);
    expect_at(80,  "s5.exit_edge", 4'b1101, 8'd0);
    expect_at(81,  "s5.reset_pll", 4'b1100, 8'd0);
    expect_at(84,  "s5.pulse",     4'b1100, 8'd0);
    expect_at(85,  "s5.wait",      4'b0100, 8'd0);
    expect_at(93,  "s5.pre_run",   4'b0100, 8'd0);
    expect_at(94,  "s5.run",       4'b0010, 8'd0);
    expect_at(105, "s5.sw_edge",   4'b0010, 8'd0);
    expect_at(106, "s5.sw_reset",  4'b1100, 8'd0);
    expect_at(110, "s5.sw_wait",   4'b0100, 8'd0);
    expect_at(118, "s5.stable_ign", 4'b0100, 8'd0);
    expect_at(119, "s5.rerun",     4'b0010, 8'd0);
    start_scn();
    wait_cyc(74);
    bus.extlock = 1'b1;
    wait_cyc(79);
    bus.sw_relock = 1'b1;
    wait_cyc(80);
    bus.sw_relock = 1'b0;
    wait_cyc(104);
    bus.sw_relock = 1'b1;
    wait_cyc(105);
    bus.sw_relock = 1'b0;
    wait_cyc(113);
    bus.sw_relock = 1'b1;
    wait_cyc(114);
    bus.sw_relock = 1'b0;
    end_scn("s5");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_ctrl.md
PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 24: PLL reset pulse width in refclk cycles (1 us at 24 MHz).
REQ-002 Parameter LOCK_WAIT, default 24000: lock timeout in refclk cycles per attempt.
REQ-003 Parameter STABLE_CYCLES, default 240: consecutive synchronized-lock cycles required before release.
REQ-004 Parameter MAX_RETRY, default 7: failed lock attempts before FAULT.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset: refclk  in  1  24 MHz reference clock, the sole clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 extlock  in  1  PLL lock indicator, asynchronous to refclk.
REQ-008 sw_relock  in  1  single-cycle request to re-run the lock sequence.
REQ-009 pll_reset  out  1  reset drive to the PLL, active-high.
REQ-010 sys_rst  out  1  system reset for PLL-clocked logic, active-high.
REQ-011 locked  out  1  high only in RUN.
REQ-012 fault  out  1  high only in FAULT.
REQ-013 relock_cnt  out  8  saturating count of lock losses seen in RUN.

Function
REQ-014 extlock SHALL pass through a 2-flop synchronizer (lock_s) before any use.
REQ-015 States: RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT; all outputs registered.
REQ-016 RESET_PLL: pll_reset=1 for exactly RST_CYCLES cycles, then WAIT_LOCK with timer cleared.
REQ-017 WAIT_LOCK: lock_s=1 -> STABLE, timer cleared; timer reaching LOCK_WAIT-1 -> retry+1, then FAULT if retry equals MAX_RETRY, else RESET_PLL.
REQ-018 lock_s=1 and timeout in the same cycle: lock wins, no retry increment.
REQ-019 STABLE: lock_s held 1 for STABLE_CYCLES consecutive cycles -> RUN; lock_s=0 -> WAIT_LOCK, timer cleared, retry unchanged.
REQ-020 sys_rst SHALL deassert exactly STABLE_CYCLES+3 refclk edges after the edge where extlock is first sampled high and stays high.
REQ-021 RUN: sys_rst=0, locked=1, retry cleared on entry; lock_s=0 -> RESET_PLL with relock_cnt+1 (saturates at 255); sw_relock -> RESET_PLL, relock_cnt unchanged.
REQ-022 RUN, lock loss and sw_relock in the same cycle: treated as lock loss (counted).
REQ-023 FAULT: pll_reset=1, sys_rst=1, fault=1 held; exit only on sw_relock -> RESET_PLL, retry cleared.
REQ-024 sw_relock SHALL be ignored in RESET_PLL, WAIT_LOCK and STABLE.
REQ-025 sys_rst=1 in every state except RUN; sys_rst SHALL assert within 3 cycles of extlock falling in RUN.

Reset
REQ-026 On reset assertion, immediately and without a clock edge: state=RESET_PLL, pll_reset=1, sys_rst=1, locked=0, fault=0, relock_cnt=0, retry=0, timers=0, synchronizer=0.
REQ-027 Reset asserted mid-operation SHALL abort any state and restart from RESET_PLL after release.

Structure
REQ-028 State encoding localparams and parameter defaults SHALL live in shared package pll_ctrl_pkg.
REQ-029 The synchronizer SHALL be a sub-module sync_2ff instantiated once; the FSM and counters stay in pll_lock_ctrl.
REQ-030 One shared timer, width sized for max(RST_CYCLES, LOCK_WAIT, STABLE_CYCLES).

Verification (RST_CYCLES=4, LOCK_WAIT=20, STABLE_CYCLES=8, MAX_RETRY=3)
REQ-031 Release reset, extlock rises at cycle 10 and stays high -> pll_reset high cycles 0-3, sys_rst falls at cycle 21, locked=1.
REQ-032 extlock held 0 -> three 4-cycle pll_reset pulses, then fault=1 at cycle 72, pll_reset stays 1.
REQ-033 extlock high 5 cycles then low during STABLE -> back to WAIT_LOCK, sys_rst stays 1, fault stays 0.
REQ-034 extlock falls in RUN -> sys_rst=1 within 3 cycles, 4-cycle pll_reset pulse, relock_cnt 0->1, relock on extlock return.
REQ-035 sw_relock pulse in FAULT with extlock=1 -> fault=0, pll_reset pulse, RUN reached, relock_cnt unchanged.
REQ-036 reset asserted mid-WAIT_LOCK -> all outputs reach REQ-026 values in the same cycle, without a clock edge.
